sram_dp_bytemask_param: RTL

SRAM_DP_BYTEMASK_PARAM -- requirements
Module: sram_dp_bytemask_param

---
 rtl/sram_dp_bytemask_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/sram_dp_bytemask_param.sv
// sram_dp_bytemask_param: dual-port byte-masked SRAM with pipelined reads and zero-fill FSM; define SRAM_RDW_BYPASS_EN for write-first reads
module sram_dp_bytemask_param #(
  parameter int DATA_W = 128,
  parameter int DEPTH = 4096,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en0,
  input  logic [DATA_W/8-1:0] wea0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  output logic [DATA_W-1:0]   rdata0,
  output logic                rvalid0,
  output logic                oob0,
  input  logic                en1,
  input  logic [DATA_W/8-1:0] wea1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                rvalid1,
  output logic                oob1,
  output logic                collision,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic                clear_done
);
  localparam int NB = DATA_W / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0] state;
  logic [AW-1:0] caddr;
  logic [1:0] en_v, rd, wr, in_rng, rv, ob;
  logic [NB-1:0] we [2];
  logic [ADDR_W-1:0] ad [2];
  logic [DATA_W-1:0] wd [2];
  logic [DATA_W-1:0] rq [2];
  logic [AW-1:0] idx [2];
  assign en_v = {en1, en0};
  assign we[0] = wea0;
  assign we[1] = wea1;
  assign ad[0] = addr0;
  assign ad[1] = addr1;
  assign wd[0] = wdata0;
  assign wd[1] = wdata1;
  assign clear_busy = state != IDLE;
  assign clear_done = state == DONE;
  assign rdata0 = rq[0];
  assign rdata1 = rq[1];
  assign rvalid0 = rv[0];
  assign rvalid1 = rv[1];
  assign oob0 = ob[0];
  assign oob1 = ob[1];
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RD_LAT-1:0] v;
    logic [DATA_W-1:0] d [RD_LAT];
    logic [DATA_W-1:0] w;
    logic o;
    assign in_rng[p] = {1'b0, ad[p]} < (ADDR_W + 1)'(DEPTH);
    assign idx[p] = ad[p][AW-1:0];
    assign rd[p] = en_v[p] & ~clear_busy & ~rst;
    assign wr[p] = rd[p] & in_rng[p] & (|we[p]);
`ifdef SRAM_RDW_BYPASS_EN
    always_comb begin
      w = in_rng[p] ? mem[idx[p]] : '0;
      for (int i = 0; i < NB; i++) begin
        if (wr[1] && we[1][i] && ad[1] == ad[p]) w[8*i +: 8] = wd[1][8*i +: 8];
        if (wr[0] && we[0][i] && ad[0] == ad[p]) w[8*i +: 8] = wd[0][8*i +: 8];
      end
    end
`else
    assign w = in_rng[p] ? mem[idx[p]] : '0;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= '0;
        o <= 1'b0;
        for (int k = 0; k < RD_LAT; k++) d[k] <= '0;
      end else begin
        v <= RD_LAT'({v, rd[p]});
        o <= rd[p] & ~in_rng[p];
        if (rd[p]) d[0] <= w;
        for (int k = 1; k < RD_LAT; k++) if (v[k-1]) d[k] <= d[k-1];
      end
    end
    assign rv[p] = v[RD_LAT-1];
    assign rq[p] = d[RD_LAT-1];
    assign ob[p] = o;
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst) mem[caddr] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (wr[1] && we[1][i]) mem[idx[1]][8*i +: 8] <= wd[1][8*i +: 8];
      if (wr[0] && we[0][i]) mem[idx[0]][8*i +: 8] <= wd[0][8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      caddr <= '0;
      collision <= 1'b0;
    end else begin
      state <= state == IDLE ? (clear_req ? CLEAR : IDLE)
             : state == CLEAR ? (caddr == AW'(DEPTH - 1) ? DONE : CLEAR) : IDLE;
      caddr <= state == CLEAR ? caddr + AW'(1) : '0;
      collision <= wr[0] & wr[1] & (ad[0] == ad[1]);
    end
  end
endmodule
